// File: rtl/ps2_kb_cmd_sequencer.sv
// Host-to-keyboard command sequencer for the PS/2 port: arbitrates LED/reset requests and handles ACK, RESEND and BAT.
// Optional typematic requester (cmd 0xF3) is enabled by defining PS2_TYPEMATIC_EN.
module ps2_kb_cmd_sequencer #(
  parameter logic [23:0] ACK_TIMEOUT = 24'd1_000_000,
  parameter logic [27:0] BAT_TIMEOUT = 28'd50_000_000,
  parameter int          MAX_RETRY   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       led_req,
  input  logic [2:0] led_state,
  input  logic       kbd_reset_req,
`ifdef PS2_TYPEMATIC_EN
  input  logic       typ_req,
  input  logic [7:0] typ_rate,
`endif
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic       tx_error,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       fwd_valid,
  output logic [7:0] fwd_data,
  output logic       cmd_busy,
  output logic       cmd_error,
  output logic [2:0] led_current
);

  localparam logic [7:0] KB_ACK    = 8'hFA;
  localparam logic [7:0] KB_RESEND = 8'hFE;
  localparam logic [7:0] KB_BAT_OK = 8'hAA;
  localparam logic [7:0] KB_BAT_NG = 8'hFC;

  typedef enum logic [2:0] {IDLE, TX_CMD, WAIT_TX, WAIT_ACK, TX_ARG, WAIT_BAT} state_t;
  typedef enum logic [1:0] {REQ_LED, REQ_RST, REQ_TYP} req_t;

  state_t      state, state_n;
  req_t        req_kind, kind_n;
  logic        arg_phase, phase_n;
  logic [7:0]  arg_byte, arg_n;
  logic [1:0]  retry_cnt, retry_n;
  logic [27:0] timer, timer_n;
  logic [2:0]  led_cur_n;
  logic        err_n, retry_go, consumed;
  logic        led_pend, rst_pend, clr_led, clr_rst;
  logic [2:0]  led_latch;
`ifdef PS2_TYPEMATIC_EN
  logic        typ_pend, clr_typ;
  logic [7:0]  typ_latch;
`endif

  always_comb begin
    state_n   = state;
    kind_n    = req_kind;
    phase_n   = arg_phase;
    arg_n     = arg_byte;
    retry_n   = retry_cnt;
    timer_n   = timer;
    led_cur_n = led_current;
    err_n     = 1'b0;
    retry_go  = 1'b0;
    clr_led   = 1'b0;
    clr_rst   = 1'b0;
`ifdef PS2_TYPEMATIC_EN
    clr_typ   = 1'b0;
`endif
    consumed  = 1'b0;
    case (state)
      IDLE: begin
        phase_n = 1'b0;
        retry_n = 2'd0;
        timer_n = 28'd0;
        if (rst_pend) begin
          kind_n  = REQ_RST;
          clr_rst = 1'b1;
          state_n = TX_CMD;
        end else if (led_pend) begin
          kind_n  = REQ_LED;
          arg_n   = {5'b0, led_latch};
          clr_led = 1'b1;
          state_n = TX_CMD;
        end
`ifdef PS2_TYPEMATIC_EN
        else if (typ_pend) begin
          kind_n  = REQ_TYP;
          arg_n   = typ_latch & 8'h7F;
          clr_typ = 1'b1;
          state_n = TX_CMD;
        end
`endif
      end
      TX_CMD, TX_ARG: state_n = WAIT_TX;
      WAIT_TX: begin
        if (tx_error) retry_go = 1'b1;
        else if (tx_done) begin
          state_n = WAIT_ACK;
          timer_n = 28'd0;
        end
      end
      WAIT_ACK: begin
        timer_n  = timer + 28'd1;
        consumed = rx_data == KB_ACK || rx_data == KB_RESEND;
        if (rx_valid && rx_data == KB_ACK) begin
          if (req_kind == REQ_RST) begin
            state_n = WAIT_BAT;
            timer_n = 28'd0;
          end else if (!arg_phase) begin
            state_n = TX_ARG;
            phase_n = 1'b1;
            retry_n = 2'd0;
          end else begin
            state_n = IDLE;
            if (req_kind == REQ_LED) led_cur_n = arg_byte[2:0];
          end
        end else if (rx_valid && rx_data == KB_RESEND) retry_go = 1'b1;
        else if (!rx_valid && timer >= ({4'd0, ACK_TIMEOUT} - 28'd1)) retry_go = 1'b1;
      end
      WAIT_BAT: begin
        timer_n  = timer + 28'd1;
        consumed = rx_data == KB_BAT_OK || rx_data == KB_BAT_NG;
        if (rx_valid && rx_data == KB_BAT_OK) begin
          state_n   = IDLE;
          led_cur_n = 3'b000;
        end else if ((rx_valid && rx_data == KB_BAT_NG) ||
                     (!rx_valid && timer >= (BAT_TIMEOUT - 28'd1))) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A failed byte is re-sent from the same phase until the retry budget runs out
    if (retry_go) begin
      if (int'(retry_cnt) < MAX_RETRY) begin
        retry_n = retry_cnt + 2'd1;
        state_n = arg_phase ? TX_ARG : TX_CMD;
      end else begin
        err_n   = 1'b1;
        state_n = IDLE;
      end
    end
  end

  always_comb begin
    tx_start = 1'b0;
    tx_data  = 8'h00;
    if (state == TX_CMD) begin
      tx_start = 1'b1;
      case (req_kind)
        REQ_RST: tx_data = 8'hFF;
        REQ_TYP: tx_data = 8'hF3;
        default: tx_data = 8'hED;
      endcase
    end else if (state == TX_ARG) begin
      tx_start = 1'b1;
      tx_data  = arg_byte;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_kind    <= REQ_LED;
      arg_phase   <= 1'b0;
      arg_byte    <= 8'h00;
      retry_cnt   <= 2'd0;
      timer       <= 28'd0;
      led_current <= 3'b000;
      cmd_error   <= 1'b0;
      cmd_busy    <= 1'b0;
      fwd_valid   <= 1'b0;
      fwd_data    <= 8'h00;
    end else begin
      state       <= state_n;
      req_kind    <= kind_n;
      arg_phase   <= phase_n;
      arg_byte    <= arg_n;
      retry_cnt   <= retry_n;
      timer       <= timer_n;
      led_current <= led_cur_n;
      cmd_error   <= err_n;
      cmd_busy    <= (state_n != IDLE);
      fwd_valid   <= rx_valid && !consumed;
      if (rx_valid && !consumed) fwd_data <= rx_data;
    end
  end

  // A request arriving in the grant cycle wins over the clear, so it is not lost
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_pend  <= 1'b0;
      rst_pend  <= 1'b0;
      led_latch <= 3'b000;
    end else begin
      if (led_req) begin
        led_pend  <= 1'b1;
        led_latch <= led_state;
      end else if (clr_led) led_pend <= 1'b0;
      if (kbd_reset_req) rst_pend <= 1'b1;
      else if (clr_rst) rst_pend <= 1'b0;
    end
  end

`ifdef PS2_TYPEMATIC_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      typ_pend  <= 1'b0;
      typ_latch <= 8'h00;
    end else if (typ_req) begin
      typ_pend  <= 1'b1;
      typ_latch <= typ_rate;
    end else if (clr_typ) typ_pend <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ps2_kb_cmd_sequencer.sv
// Randomized bench for ps2_kb_cmd_sequencer: plays transmit engine and keyboard, predicts bytes, errors and LED state.
module tb_ps2_kb_cmd_sequencer;
  localparam logic [23:0] ACK_TO = 24'd40;
  localparam logic [27:0] BAT_TO = 28'd120;
  localparam int MAX_RETRY = 2;

  logic clock = 1'b0;
  logic reset, led_req, kbd_reset_req, tx_done, tx_error, rx_valid;
  logic [2:0] led_state;
  logic [7:0] rx_data;
  logic tx_start, fwd_valid, cmd_busy, cmd_error;
  logic [7:0] tx_data, fwd_data;
  logic [2:0] led_current;

  int checks = 0, errors = 0;
  int tx_cnt = 0, fwd_cnt = 0, err_cnt = 0;
  int exp_tx = 0, exp_fwd = 0, exp_err = 0;
  logic [2:0] exp_led = 3'b000;
  int script[$];

  ps2_kb_cmd_sequencer #(.ACK_TIMEOUT(ACK_TO), .BAT_TIMEOUT(BAT_TO), .MAX_RETRY(MAX_RETRY)) dut (
    .clock(clock), .reset(reset), .led_req(led_req), .led_state(led_state),
    .kbd_reset_req(kbd_reset_req), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .tx_error(tx_error), .rx_valid(rx_valid), .rx_data(rx_data),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .cmd_busy(cmd_busy),
    .cmd_error(cmd_error), .led_current(led_current));

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (tx_start) tx_cnt++;
    if (fwd_valid) fwd_cnt++;
    if (cmd_error) err_cnt++;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_noise(input logic [7:0] b);
    send_rx(b);
    exp_fwd++;
    checkOutput("fwd_valid", fwd_valid, 1);
    checkOutput("fwd_data", fwd_data, b);
  endtask

  function automatic logic [7:0] rand_noise(input logic [7:0] x0, input logic [7:0] x1);
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (b == x0 || b == x1);
    return b;
  endfunction

  // code: [3:0] reply kind, [4] noise before reply, [15:8] noise byte
  function automatic int pick(input bit bat);
    int r, code;
    if (script.size() > 0) return script.pop_front();
    r = int'($urandom_range(0, 99));
    if (bat) code = (r < 70) ? 0 : (r < 85) ? 1 : 2;
    else     code = (r < 50) ? 0 : (r < 70) ? 1 : (r < 80) ? 2 : 3;
    if ($urandom_range(0, 3) == 0)
      code = code | 16 | (int'(bat ? rand_noise(8'hAA, 8'hFC) : rand_noise(8'hFA, 8'hFE)) << 8);
    return code;
  endfunction

  task automatic wait_tx(input logic [7:0] expb, input int bound, input string tag);
    int n = 0;
    while (!tx_start && n < bound) begin tick(); n++; end
    checkOutput({tag, "_start"}, tx_start, 1);
    if (tx_start) begin
      exp_tx++;
      checkOutput({tag, "_data"}, tx_data, expb);
    end
  endtask

  task automatic wait_err(input int bound, input string tag);
    int n = 0;
    while (!cmd_error && n < bound) begin tick(); n++; end
    exp_err++;
    checkOutput(tag, err_cnt, exp_err);
    tick();
    checkOutput({tag, "_len"}, cmd_error, 0);
  endtask

  task automatic applyStimulus(input bit rst, input bit led, input logic [2:0] v);
    led_state     = v;
    led_req       = led;
    kbd_reset_req = rst;
    tick();
    led_req       = 1'b0;
    kbd_reset_req = 1'b0;
    led_state     = 3'($urandom);
  endtask

  // Plays one full command exchange and predicts its outcome from the retry rules
  task automatic run_seq(input bit is_rst, input logic [2:0] lv, input bit more);
    logic [7:0] bytes[2];
    int nb, tries, code;
    bit done, aborted;
    bytes[0] = is_rst ? 8'hFF : 8'hED;
    bytes[1] = {5'b0, lv};
    nb = is_rst ? 1 : 2;
    aborted = 1'b0;
    for (int i = 0; i < nb && !aborted; i++) begin
      tries = 0;
      done  = 1'b0;
      while (!done && !aborted) begin
        wait_tx(bytes[i], int'(ACK_TO) + 20, (i == 0) ? "tx_cmd" : "tx_arg");
        tick();
        checkOutput("tx_one_cycle", tx_start, 0);
        repeat ($urandom_range(0, 3)) tick();
        code = pick(1'b0);
        if ((code & 15) == 3) begin
          tx_error = 1'b1; tick(); tx_error = 1'b0;
          tries++;
        end else begin
          tx_done = 1'b1; tick(); tx_done = 1'b0;
          if (code[4]) send_noise(code[15:8]);
          if ((code & 15) == 0) begin
            send_rx(8'hFA);
            checkOutput("ack_not_fwd", fwd_valid, 0);
            done = 1'b1;
          end else begin
            if ((code & 15) == 1) begin
              send_rx(8'hFE);
              checkOutput("resend_not_fwd", fwd_valid, 0);
            end
            tries++;
          end
        end
        if (!done && tries > MAX_RETRY) aborted = 1'b1;
      end
    end
    if (aborted) wait_err(int'(ACK_TO) + 20, "abort_err");
    else if (is_rst) begin
      code = pick(1'b1);
      if (code[4]) send_noise(code[15:8]);
      case (code & 15)
        0: begin
          send_rx(8'hAA);
          checkOutput("bat_not_fwd", fwd_valid, 0);
          exp_led = 3'b000;
        end
        1: begin
          send_rx(8'hFC);
          checkOutput("fc_not_fwd", fwd_valid, 0);
          wait_err(4, "bat_fail_err");
        end
        default: wait_err(int'(BAT_TO) + 20, "bat_timeout_err");
      endcase
    end else exp_led = lv;
    checkOutput("led_current", led_current, exp_led);
    if (!more) checkOutput("busy_done", cmd_busy, 0);
    checkOutput("tx_count", tx_cnt, exp_tx);
    checkOutput("fwd_count", fwd_cnt, exp_fwd);
    checkOutput("err_count", err_cnt, exp_err);
  endtask

  initial begin
    bit rs;
    logic [2:0] v;
    reset = 1'b1; led_req = 1'b0; kbd_reset_req = 1'b0; led_state = 3'b000;
    tx_done = 1'b0; tx_error = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick();
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_fwd_valid", fwd_valid, 0);
    checkOutput("rst_fwd_data", fwd_data, 0);
    checkOutput("rst_busy", cmd_busy, 0);
    checkOutput("rst_error", cmd_error, 0);
    checkOutput("rst_led", led_current, 0);
    reset = 1'b0;
    tick();

    $display("[TB] LED update, clean ACKs");
    script = '{0, 0};
    applyStimulus(1'b0, 1'b1, 3'b101);
    run_seq(1'b0, 3'b101, 1'b0);

    $display("[TB] LED update with one RESEND");
    script = '{1, 0, 0};
    applyStimulus(1'b0, 1'b1, 3'b010);
    run_seq(1'b0, 3'b010, 1'b0);

    $display("[TB] LED update aborted by timeouts");
    script = '{2, 2, 2};
    applyStimulus(1'b0, 1'b1, 3'b111);
    run_seq(1'b0, 3'b111, 1'b0);

    $display("[TB] same-cycle reset and LED requests");
    script = '{0, 0, 0, 0};
    applyStimulus(1'b1, 1'b1, 3'b011);
    run_seq(1'b1, 3'b000, 1'b1);
    run_seq(1'b0, 3'b011, 1'b0);

    $display("[TB] scancode during WAIT_ACK");
    script = '{0 | 16 | (8'h1C << 8), 0};
    applyStimulus(1'b0, 1'b1, 3'b100);
    run_seq(1'b0, 3'b100, 1'b0);

    $display("[TB] keyboard reset with BAT failure");
    script = '{0, 1};
    applyStimulus(1'b1, 1'b0, 3'b000);
    run_seq(1'b1, 3'b000, 1'b0);

    $display("[TB] reset asserted during WAIT_TX");
    applyStimulus(1'b1, 1'b0, 3'b000);
    wait_tx(8'hFF, 10, "mid_tx");
    tick();
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_busy", cmd_busy, 0);
    checkOutput("mid_rst_led", led_current, 0);
    tick();
    checkOutput("mid_rst_tx_start", tx_start, 0);
    checkOutput("mid_rst_error", cmd_error, 0);
    checkOutput("mid_rst_fwd", fwd_valid, 0);
    reset = 1'b0;
    exp_led = 3'b000;
    repeat (5) tick();
    checkOutput("mid_rst_no_tx", tx_cnt, exp_tx);
    checkOutput("mid_rst_idle", cmd_busy, 0);

    $display("[TB] randomized sequences");
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) send_noise(8'($urandom));
      repeat ($urandom_range(0, 4)) tick();
      rs = ($urandom_range(0, 9) < 3);
      v  = 3'($urandom);
      applyStimulus(rs, !rs, v);
      run_seq(rs, v, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
